// File: rtl/scrypt_pkg.sv
// Shared definitions for the scrypt ROMix sequencing logic: block width,
// controller state encoding and the Integerify index extraction.
package scrypt_pkg;

    localparam int BLK_W   = 1024;
    localparam int INT_LSB = 512;   // first 32-bit word of the last 64-byte sub-block

    typedef logic [BLK_W-1:0] block_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_ISSUE,
        S_FILL_WAIT,
        S_MIX_READ,
        S_MIX_ISSUE,
        S_MIX_WAIT,
        S_DONE
    } state_t;

    // Low 32 bits of Integerify(X); callers truncate to their address width.
    function automatic logic [31:0] integerify(input block_t x);
        return x[INT_LSB +: 32];
    endfunction

endpackage

// File: rtl/scrypt_romix_ctrl.sv
// ROMix sequencer: drives one external blockmix through N fill passes that
// store X into the scratchpad, then N mix passes that fold V[j] back into X.
module scrypt_romix_ctrl
    import scrypt_pkg::*;
#(
    parameter int N      = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [BLK_W-1:0]  data_in,
    output logic              busy,
    output logic              done,
    output logic [BLK_W-1:0]  data_out,
    output logic [BLK_W-1:0]  bm_data,
    output logic              bm_enable,
    input  logic [BLK_W-1:0]  bm_hash_out,
    input  logic              bm_hash_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [BLK_W-1:0]  mem_wdata,
    output logic              mem_re,
    input  logic [BLK_W-1:0]  mem_rdata
);

    localparam int             I_W    = ADDR_W + 1;
    localparam logic [I_W-1:0] I_LAST = I_W'(N - 1);

    state_t             state, state_nxt;
    block_t             x, t;
    logic [I_W-1:0]     i;
    logic               last;
    logic [ADDR_W-1:0]  j;
    block_t             mix_in;

    assign last   = (i == I_LAST);
    assign j      = ADDR_W'(integerify(x));
    assign mix_in = x ^ mem_rdata;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Completion pulses only matter in the two wait states, so a stray or
    // early bm_hash_done elsewhere falls through untouched.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (start) state_nxt = S_FILL_ISSUE;
            S_FILL_ISSUE: state_nxt = S_FILL_WAIT;
            S_FILL_WAIT:  if (bm_hash_done) state_nxt = last ? S_MIX_READ : S_FILL_ISSUE;
            S_MIX_READ:   state_nxt = S_MIX_ISSUE;
            S_MIX_ISSUE:  state_nxt = S_MIX_WAIT;
            S_MIX_WAIT:   if (bm_hash_done) state_nxt = last ? S_DONE : S_MIX_READ;
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = 1'b0;
        bm_data   = '0;
        bm_enable = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_re    = 1'b0;
        case (state)
            S_FILL_ISSUE: begin
                mem_we    = 1'b1;
                mem_addr  = i[ADDR_W-1:0];
                mem_wdata = x;
                bm_data   = x;
                bm_enable = 1'b1;
            end
            S_FILL_WAIT: bm_data = x;
            S_MIX_READ: begin
                mem_re   = 1'b1;
                mem_addr = j;
            end
            S_MIX_ISSUE: begin
                bm_data   = mix_in;
                bm_enable = 1'b1;
            end
            S_MIX_WAIT: bm_data = t;
            S_DONE:     done = 1'b1;
            default: ;
        endcase
    end

    // data_out is loaded on the final completion so it is already valid
    // during the done cycle and then holds.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x        <= '0;
            t        <= '0;
            i        <= '0;
            data_out <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    x <= data_in;
                    i <= '0;
                end
                S_FILL_WAIT: if (bm_hash_done) begin
                    x <= bm_hash_out;
                    i <= last ? '0 : i + 1'b1;
                end
                S_MIX_ISSUE: t <= mix_in;
                S_MIX_WAIT: if (bm_hash_done) begin
                    x <= bm_hash_out;
                    if (last) data_out <= bm_hash_out;
                    else      i <= i + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scrypt_romix_ctrl.sv
// Bench for scrypt_romix_ctrl with a +1 blockmix stub and a behavioural scratchpad.
module tb_scrypt_romix_ctrl;

    localparam int N       = 4;
    localparam int ADDR_W  = 2;
    localparam int L       = 3;
    localparam int EXP_LAT = N * (L + 1) + N * (L + 2) + 1;
    localparam int BW      = 1024;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              start;
    logic [BW-1:0]     data_in;
    logic              busy, done;
    logic [BW-1:0]     data_out, bm_data, bm_hash_out, mem_wdata, mem_rdata;
    logic              bm_enable, bm_hash_done, mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic              inject;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scrypt_romix_ctrl #(.N(N), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .data_in(data_in),
        .busy(busy), .done(done), .data_out(data_out),
        .bm_data(bm_data), .bm_enable(bm_enable),
        .bm_hash_out(bm_hash_out), .bm_hash_done(bm_hash_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    // Blockmix stub: result = input + 1, completion L cycles after enable.
    logic [BW-1:0] stub_q;
    int            stub_cnt;
    logic          stub_done;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stub_q <= '0; stub_cnt <= 0; stub_done <= 1'b0;
        end else begin
            stub_done <= 1'b0;
            if (bm_enable) begin
                stub_q   <= bm_data + 1;
                stub_cnt <= L - 1;
            end else if (stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) stub_done <= 1'b1;
            end
        end
    end
    assign bm_hash_out  = stub_q;
    assign bm_hash_done = stub_done | inject;

    logic [BW-1:0] vmem [N];
    always @(posedge clk) begin
        if (mem_we) vmem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= vmem[mem_addr];
    end

    int n_en = 0, n_we = 0, n_re = 0, n_both = 0, n_done = 0;
    always @(posedge clk) begin
        if (bm_enable)       n_en   <= n_en + 1;
        if (mem_we)          n_we   <= n_we + 1;
        if (mem_re)          n_re   <= n_re + 1;
        if (mem_we && mem_re) n_both <= n_both + 1;
        if (done)            n_done <= n_done + 1;
    end

    // ROMix with a +1 mixing function, straight from the algorithm.
    function automatic logic [BW-1:0] model(input logic [BW-1:0] x0);
        logic [BW-1:0] x, xs;
        logic [BW-1:0] v [N];
        int jj;
        x = x0;
        for (int k = 0; k < N; k++) begin v[k] = x; x = x + 1; end
        for (int k = 0; k < N; k++) begin
            xs = x >> 512;
            jj = int'(xs[ADDR_W-1:0]);
            x  = (x ^ v[jj]) + 1;
        end
        return x;
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got low64=%0h want low64=%0h", nm, act[63:0], exp[63:0]);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // mode 0: plain, 1: start re-pulsed mid-FILL, 2: spurious done in MIX_READ/MIX_ISSUE
    task automatic run_op(input logic [BW-1:0] din, input logic [BW-1:0] exp,
                          input string nm, input int mode);
        int cyc, inj_left, e0, w0, r0, b0, d0;
        bit got;
        e0 = n_en; w0 = n_we; r0 = n_re; b0 = n_both; d0 = n_done;
        cyc = 0; got = 0; inj_left = 0;
        @(negedge clk);
        data_in = din; start = 1'b1;
        while (cyc < 200 && !got) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            data_in = din;
            if (cyc == 1) chk_int({nm, "_busy"}, int'(busy), 1);
            if (done) got = 1;
            if (mode == 1 && cyc == 6) begin start = 1'b1; data_in = ~din; end
            if (inj_left > 0) begin
                inj_left--;
                if (inj_left == 0) inject = 1'b0;
            end else if (mode == 2 && mem_re) begin
                inject = 1'b1; inj_left = 2;
            end
        end
        inject = 1'b0;
        if (!got) begin
            failures++; checks++;
            $display("FAIL %s_timeout: no done within %0d cycles", nm, cyc);
        end else begin
            chk_int({nm, "_latency"}, cyc, EXP_LAT);
            chk({nm, "_data_out"}, data_out, exp);
        end
        repeat (3) @(negedge clk);
        chk_int({nm, "_done_pulses"}, n_done - d0, 1);
        chk_int({nm, "_bm_enable"}, n_en - e0, 2 * N);
        chk_int({nm, "_mem_we"}, n_we - w0, N);
        chk_int({nm, "_mem_re"}, n_re - r0, N);
        chk_int({nm, "_we_re_overlap"}, n_both - b0, 0);
        chk_int({nm, "_idle_busy"}, int'(busy), 0);
        chk({nm, "_held"}, data_out, exp);
    endtask

    typedef struct {
        logic [BW-1:0] din;
        logic [BW-1:0] exp;
    } vec_t;

    initial begin
        vec_t          tbl [3];
        logic [BW-1:0] b, r;
        int            k;

        b = '0; b[512] = 1'b1;
        tbl[0].din = '0; tbl[0].exp = 1024'd8;
        tbl[1].din = b;  tbl[1].exp = b + 8;
        tbl[2].din = '1; tbl[2].exp = '0;

        n_rst = 1'b0; start = 1'b0; data_in = '0; inject = 1'b0;
        repeat (2) @(negedge clk);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_done", int'(done), 0);
        chk("rst_data_out", data_out, '0);
        chk_int("rst_strobes", int'({bm_enable, mem_we, mem_re}), 0);
        n_rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            run_op(tbl[v].din, tbl[v].exp, $sformatf("tbl%0d", v), 0);
            if (v == 0)
                for (int a = 0; a < N; a++) chk($sformatf("fill_v%0d", a), vmem[a], BW'(a));
        end

        run_op('0, 1024'd8, "restart_mid_fill", 1);

        // Abort during MIX_WAIT, then confirm a clean rerun.
        @(negedge clk);
        data_in = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!mem_re && k < 100) begin @(negedge clk); k++; end
        chk_int("reach_mix_read", int'(mem_re), 1);
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk_int("abort_flags", int'({busy, done, bm_enable, mem_we, mem_re}), 0);
        chk("abort_data_out", data_out, '0);
        chk("abort_bm_data", bm_data, '0);
        chk("abort_mem_wdata", mem_wdata, '0);
        chk_int("abort_mem_addr", int'(mem_addr), 0);
        @(negedge clk);
        n_rst = 1'b1;
        run_op('0, 1024'd8, "after_abort", 0);

        run_op(tbl[1].din, tbl[1].exp, "spurious_tbl1", 2);
        for (int n = 0; n < 5; n++) begin
            for (int w = 0; w < BW / 32; w++) r[w*32 +: 32] = $urandom;
            run_op(r, model(r), $sformatf("rand%0d", n), (n == 2) ? 2 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
